// File: rtl/wf_issue_arbiter.sv
// Round-robin wavefront issue arbiter: merges readiness sources, picks one
// wavefront per request and holds it under a valid/ack handshake, with per-WF hold-off.
module wf_issue_arbiter #(
  parameter int NUM_WF  = 40,
  parameter int WFID_W  = 6,
  parameter int HOLDOFF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] ready_arry_gpr,
  input  logic [NUM_WF-1:0] ready_arry_oth,
  input  logic              issue_ack,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  output logic              issue_valid,
  output logic [WFID_W-1:0] issue_wfid,
  output logic [NUM_WF-1:0] issue_onehot
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [WFID_W:0] NUM_WF_EXT = (WFID_W+1)'(NUM_WF);

  state_t            state_q, state_d;
  logic [WFID_W-1:0] ptr_q, ptr_d;
  logic [WFID_W-1:0] wfid_q, wfid_d;
  logic [2:0]        cnt_q [NUM_WF];
  logic [2:0]        cnt_d [NUM_WF];

  logic [NUM_WF-1:0] holdoff_mask;
  logic [NUM_WF-1:0] flush_mask;
  logic [NUM_WF-1:0] cand;
  logic              pick_found;
  logic [WFID_W-1:0] pick;
  logic              issued;

  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      holdoff_mask[i] = (cnt_q[i] != 3'd0);
      // Out-of-range ids never match any index, so they mask nothing.
      flush_mask[i]   = flush_valid && (flush_wfid == WFID_W'(i));
    end
    cand = ready_arry_gpr & ready_arry_oth & ~holdoff_mask & ~flush_mask;
  end

  // Search starts just past the last granted WF and wraps at NUM_WF-1.
  always_comb begin
    logic [WFID_W:0] sum;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_found = 1'b0;
    pick       = '0;
    sum        = '0;
    for (int k = 1; k <= NUM_WF; k++) begin
      sum = {1'b0, ptr_q} + (WFID_W+1)'(k);
      if (sum >= NUM_WF_EXT) sum = sum - NUM_WF_EXT;
      if (!pick_found && cand[sum[WFID_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = sum[WFID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wfid_d  = wfid_q;
    issued  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          wfid_d  = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack takes priority over a same-WF flush: the WF counts as issued.
        if (issue_ack) begin
          ptr_d   = wfid_q;
          issued  = 1'b1;
          state_d = IDLE;
        end else if (flush_valid && (flush_wfid == wfid_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      cnt_d[i] = (cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1 : 3'd0;
      if (flush_mask[i]) cnt_d[i] = 3'd0;
      if (issued && (wfid_q == WFID_W'(i))) cnt_d[i] = 3'(HOLDOFF);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= WFID_W'(NUM_WF - 1);
      wfid_q  <= '0;
      // NOTE: the hold-off array is reset explicitly; a stale count would mask a WF after reset.
      for (int i = 0; i < NUM_WF; i++) cnt_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wfid_q  <= wfid_d;
      for (int i = 0; i < NUM_WF; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign issue_valid = (state_q == REQ);
  assign issue_wfid  = wfid_q;

  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      issue_onehot[i] = issue_valid && (wfid_q == WFID_W'(i));
    end
  end

endmodule

// File: tb/tb_wf_issue_arbiter.sv
// Directed bench for wf_issue_arbiter: a vector table for round-robin, hold-off
// and flush masking, plus hand sequences for stall, REQ flush and mid-op reset.
module tb_wf_issue_arbiter;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_WF-1:0] gpr, oth;
  logic              ack, fv;
  logic [WFID_W-1:0] fid;
  logic              issue_valid;
  logic [WFID_W-1:0] issue_wfid;
  logic [NUM_WF-1:0] issue_onehot;

  int checks = 0;
  int errors = 0;

  wf_issue_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .HOLDOFF(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ready_arry_gpr (gpr),
    .ready_arry_oth (oth),
    .issue_ack      (ack),
    .flush_valid    (fv),
    .flush_wfid     (fid),
    .issue_valid    (issue_valid),
    .issue_wfid     (issue_wfid),
    .issue_onehot   (issue_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_WF-1:0] gpr;
    logic [NUM_WF-1:0] oth;
    logic              ack;
    logic              fv;
    logic [WFID_W-1:0] fid;
    logic              ev;
    logic [WFID_W-1:0] ew;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [NUM_WF-1:0] wf(input int i);
    logic [NUM_WF-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ev, input logic [WFID_W-1:0] ew);
    check({name, "_valid"}, 64'(issue_valid), 64'(ev));
    check({name, "_onehot"}, 64'(issue_onehot), ev ? 64'(wf(int'(ew))) : 64'd0);
    if (ev) check({name, "_wfid"}, 64'(issue_wfid), 64'(ew));
  endtask

  task automatic step(input logic [NUM_WF-1:0] g, input logic [NUM_WF-1:0] o, input logic a,
                      input logic f, input logic [WFID_W-1:0] id);
    gpr = g; oth = o; ack = a; fv = f; fid = id;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [NUM_WF-1:0] g, input logic [NUM_WF-1:0] o, input logic a,
                     input logic f, input logic [WFID_W-1:0] id, input logic ev,
                     input logic [WFID_W-1:0] ew);
    vec_t v;
    v.gpr = g; v.oth = o; v.ack = a; v.fv = f; v.fid = id; v.ev = ev; v.ew = ew;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NUM_WF-1:0] all1, t2, none;
    all1 = '1;
    none = '0;
    t2   = wf(3) | wf(7) | wf(39);

    // Round-robin over {3,7,39}; the first entry acks the post-reset grant of WF0.
    add(t2, all1, 1, 0, 0, 0, 0);
    add(t2, all1, 0, 0, 0, 1, 3);
    add(t2, all1, 1, 0, 0, 0, 0);
    add(t2, all1, 0, 0, 0, 1, 7);
    add(t2, all1, 1, 0, 0, 0, 0);
    add(t2, all1, 0, 0, 0, 1, 39);
    add(t2, all1, 1, 0, 0, 0, 0);
    add(t2, all1, 0, 0, 0, 1, 3);
    add(t2, all1, 1, 0, 0, 0, 0);
    add(t2, all1, 0, 0, 0, 1, 7);
    // Hold-off on a lone WF5; ack in IDLE is ignored.
    add(wf(5), all1, 1, 0, 0, 0, 0);
    add(wf(5), all1, 0, 0, 0, 1, 5);
    add(wf(5), all1, 1, 0, 0, 0, 0);
    add(wf(5), all1, 1, 0, 0, 0, 0);
    add(wf(5), all1, 0, 0, 0, 0, 0);
    add(wf(5), all1, 0, 0, 0, 1, 5);
    // Flush and other-source masking in IDLE; out-of-range flush id ignored.
    add(wf(20), all1, 1, 0, 0, 0, 0);
    add(wf(20), all1, 0, 1, 20, 0, 0);
    add(wf(20), ~wf(20), 0, 0, 0, 0, 0);
    add(wf(20), all1, 0, 1, 52, 1, 20);
    add(wf(9), all1, 1, 0, 0, 0, 0);
    add(wf(9), all1, 0, 0, 0, 1, 9);

    // T1: reset with everything ready.
    rst = 1'b1; gpr = all1; oth = all1; ack = 0; fv = 0; fid = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("t1_in_reset", 0, 0);
    check("t1_wfid_reset", 64'(issue_wfid), 64'd0);
    #2 rst = 1'b0;
    #1;
    check_out("t1_release", 0, 0);
    @(posedge clk);
    #1;
    check_out("t1_first_grant", 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].gpr, vecs[i].oth, vecs[i].ack, vecs[i].fv, vecs[i].fid);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ew);
    end

    // T4: WF9 stalled 10 cycles, ready bit dropped at cycle 3.
    for (int c = 1; c <= 10; c++) begin
      step((c >= 3) ? none : wf(9), all1, 0, 0, 0);
      check_out($sformatf("t4_stall%0d", c), 1, 9);
    end
    step(none, all1, 1, 0, 0);
    check_out("t4_ack", 0, 0);

    // T5: flush without ack withdraws, no pointer move, no hold-off.
    step(wf(12), all1, 0, 0, 0);
    check_out("t5_req12", 1, 12);
    step(wf(12), all1, 0, 1, 12);
    check_out("t5_flush12", 0, 0);
    step(wf(5) | wf(12), all1, 0, 0, 0);
    check_out("t5_regrant12", 1, 12);
    step(wf(5) | wf(12), all1, 0, 1, 5);
    check_out("t5_other_flush", 1, 12);
    step(wf(5) | wf(12), all1, 1, 1, 12);
    check_out("t5_ack_flush", 0, 0);
    step(wf(5) | wf(12), all1, 0, 0, 0);
    check_out("t5_12_held_off", 1, 5);

    // T6: reset while in REQ with WF20 held off.
    step(wf(20) | wf(21), all1, 1, 0, 0);
    step(wf(20) | wf(21), all1, 0, 0, 0);
    check_out("t6_req20", 1, 20);
    step(wf(20) | wf(21), all1, 1, 0, 0);
    step(wf(20) | wf(21), all1, 0, 0, 0);
    check_out("t6_req21", 1, 21);
    #2 rst = 1'b1;
    #1;
    check_out("t6_async_drop", 0, 0);
    check("t6_wfid_reset", 64'(issue_wfid), 64'd0);
    gpr = wf(20); ack = 0;
    @(posedge clk);
    #1;
    check_out("t6_in_reset", 0, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("t6_no_holdoff", 1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
